// File: rtl/bp_pkg.sv
// Shared types for the dynamic branch predictor.
// Counter codes, redirect selects and FSM states.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_e;

  localparam logic [1:0] REDIR_NONE = 2'b00;
  localparam logic [1:0] REDIR_TGT  = 2'b01;
  localparam logic [1:0] REDIR_SEQ  = 2'b10;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [1:0] sat_upd(
    input logic [1:0] c,
    input logic       taken
  );
    logic [1:0] r;
    r = c;
    if (taken && c != ST)
      r = c + 2'd1;
    else if (!taken && c != SNT)
      r = c - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table of 2-bit saturating counters.
// Async read port; sync write port shared by init and update.
module bp_pht
  import bp_pkg::*;
#(
  parameter int         INDEX_W  = 10,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic               clk,
  input  logic               init_we_i,
  input  logic [INDEX_W-1:0] init_idx_i,
  input  logic               upd_we_i,
  input  logic [INDEX_W-1:0] upd_idx_i,
  input  logic               upd_taken_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic [1:0]         rd_cnt_o
);

  localparam int N = 1 << INDEX_W;

  logic [1:0] mem_q [N];

  // Read-old: a same-cycle update is seen only from the next cycle.
  assign rd_cnt_o = mem_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (init_we_i)
      mem_q[init_idx_i] <= CNT_INIT;
    else if (upd_we_i)
      mem_q[upd_idx_i] <= sat_upd(mem_q[upd_idx_i], upd_taken_i);
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction sequencer: predicts in Decode, resolves in Execute,
// drives redirect/flush on mispredict and keeps resolve statistics.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int         INDEX_W  = 10,
  parameter int         GHR_W    = 0,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pcD,
  input  logic              branchD,
  input  logic              flushE,
  input  logic              actual_takenE,
  output logic              predict_takenD,
  output logic              mispredictE,
  output logic [1:0]        redirect_selE,
  output logic              flushFD,
  output logic              flushDE,
  output logic              ready,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int GHR_LEN = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [INDEX_W-1:0] IDX_LAST = '1;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [GHR_LEN-1:0] ghr_q, ghr_d;
  logic               validE_q, validE_d;
  logic               predE_q, predE_d;
  logic [INDEX_W-1:0] idxE_q, idxE_d;
  logic [STAT_W-1:0]  nbr_q, nbr_d;
  logic [STAT_W-1:0]  nmis_q, nmis_d;

  logic [INDEX_W-1:0] ghr_ext;
  logic [INDEX_W-1:0] idxD;
  logic [1:0]         cntD;
  logic               init_we;
  logic               upd_we;
  logic               mis;

  logic unused_pc;
  assign unused_pc = ^{pcD[31:INDEX_W+2], pcD[1:0]};

  always_comb begin
    ghr_ext = '0;
    if (GHR_W > 0)
      ghr_ext[GHR_LEN-1:0] = ghr_q;
  end

  assign idxD    = pcD[INDEX_W+1:2] ^ ghr_ext;
  assign init_we = (state_q == INIT);
  assign upd_we  = validE_q && (state_q == RUN);
  assign mis     = validE_q && (actual_takenE != predE_q);

  bp_pht #(
    .INDEX_W  (INDEX_W),
    .CNT_INIT (CNT_INIT)
  ) u_pht (
    .clk         (clk),
    .init_we_i   (init_we),
    .init_idx_i  (idx_q),
    .upd_we_i    (upd_we),
    .upd_idx_i   (idxE_q),
    .upd_taken_i (actual_takenE),
    .rd_idx_i    (idxD),
    .rd_cnt_o    (cntD)
  );

  assign ready            = (state_q == RUN);
  assign predict_takenD   = branchD & ready & cntD[1] & ~mis;
  assign mispredictE      = mis;
  assign flushFD          = mis;
  assign flushDE          = mis;
  assign redirect_selE    = !mis ? REDIR_NONE :
                            actual_takenE ? REDIR_TGT : REDIR_SEQ;
  assign stat_branches    = nbr_q;
  assign stat_mispredicts = nmis_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ghr_d    = ghr_q;
    nbr_d    = nbr_q;
    nmis_d   = nmis_q;
    // A resolving mispredict squashes whatever branch sits in Decode.
    validE_d = branchD & ~flushE & ~mis;
    predE_d  = predict_takenD;
    idxE_d   = idxD;
    unique case (state_q)
      INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST)
          state_d = RUN;
      end
      RUN: begin
        if (upd_we && GHR_W > 0)
          ghr_d = GHR_LEN'({ghr_q, actual_takenE});
      end
      default: state_d = INIT;
    endcase
    if (validE_q) begin
      nbr_d = nbr_q + 1'b1;
      if (mis)
        nmis_d = nmis_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      idx_q    <= '0;
      ghr_q    <= '0;
      validE_q <= 1'b0;
      predE_q  <= 1'b0;
      idxE_q   <= '0;
      nbr_q    <= '0;
      nmis_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ghr_q    <= ghr_d;
      validE_q <= validE_d;
      predE_q  <= predE_d;
      idxE_q   <= idxE_d;
      nbr_q    <= nbr_d;
      nmis_q   <= nmis_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: bimodal instance plus a
// 2-bit gshare instance, checked against hand-computed vectors.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcD;
  logic        branchD, flushE, tk;
  logic        pred, mis, ffd, fde, rdy;
  logic [1:0]  redir;
  logic [31:0] nbr, nmis;

  logic [31:0] g_pc;
  logic        g_br, g_tk;
  logic        g_pred, g_mis, g_ffd, g_fde, g_rdy;
  logic [1:0]  g_redir;
  logic [31:0] g_nbr, g_nmis;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.INDEX_W(4), .GHR_W(0)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .pcD              (pcD),
    .branchD          (branchD),
    .flushE           (flushE),
    .actual_takenE    (tk),
    .predict_takenD   (pred),
    .mispredictE      (mis),
    .redirect_selE    (redir),
    .flushFD          (ffd),
    .flushDE          (fde),
    .ready            (rdy),
    .stat_branches    (nbr),
    .stat_mispredicts (nmis)
  );

  branch_predict_ctrl #(.INDEX_W(4), .GHR_W(2)) u_g (
    .clk              (clk),
    .rst              (rst),
    .pcD              (g_pc),
    .branchD          (g_br),
    .flushE           (1'b0),
    .actual_takenE    (g_tk),
    .predict_takenD   (g_pred),
    .mispredictE      (g_mis),
    .redirect_selE    (g_redir),
    .flushFD          (g_ffd),
    .flushDE          (g_fde),
    .ready            (g_rdy),
    .stat_branches    (g_nbr),
    .stat_mispredicts (g_nmis)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] pat   = 6'b010101;
  logic [5:0] exp_p = 6'b010000;
  logic [5:0] exp_m = 6'b000101;
  logic [1:0] exp_g [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    int n;
    rst = 1'b1; pcD = '0; branchD = 0; flushE = 0; tk = 0;
    g_pc = '0; g_br = 0; g_tk = 0;
    repeat (2) cyc;
    pcD = 32'h40; branchD = 1;
    #1;
    chk("rst_ready", {31'd0, rdy}, 0);
    chk("rst_pred", {31'd0, pred}, 0);
    chk("rst_outs", {27'd0, mis, redir, ffd, fde}, 0);
    branchD = 0;
    rst = 1'b0;

    // Test 1: reset pulse mid-init
    repeat (7) cyc;
    rst = 1'b1;
    #1;
    chk("t1_ready", {31'd0, rdy}, 0);
    chk("t1_idx", {28'd0, u_dut.idx_q}, 0);
    cyc;
    rst = 1'b0;
    n = 0;
    while (!rdy && n < 40) begin
      cyc;
      n++;
    end
    chk("t1_init_len", n, 16);
    chk("t1_stats", nbr | nmis, 0);

    // Test 2: two taken resolves at pc 0x40
    pcD = 32'h40; branchD = 1;
    #1 chk("t2_pred0", {31'd0, pred}, 0);
    cyc; branchD = 0; tk = 1;
    #1;
    chk("t2_mis", {31'd0, mis}, 1);
    chk("t2_redir", {30'd0, redir}, 1);
    chk("t2_flush", {30'd0, ffd, fde}, 3);
    cyc;
    chk("t2_e0a", {30'd0, u_dut.u_pht.mem_q[0]}, 2);
    chk("t2_st1", {nbr[15:0], nmis[15:0]}, 32'h0001_0001);
    branchD = 1; tk = 0;
    #1 chk("t2_pred1", {31'd0, pred}, 1);
    cyc; branchD = 0; tk = 1;
    #1 chk("t2_nomis", {29'd0, mis, redir}, 0);
    cyc;
    chk("t2_e0b", {30'd0, u_dut.u_pht.mem_q[0]}, 3);
    chk("t2_st2", {nbr[15:0], nmis[15:0]}, 32'h0002_0001);

    // Test 3: strongly taken entry resolves not-taken
    branchD = 1;
    #1 chk("t3_pred", {31'd0, pred}, 1);
    cyc; branchD = 0; tk = 0;
    #1;
    chk("t3_mis", {31'd0, mis}, 1);
    chk("t3_redir", {30'd0, redir}, 2);
    cyc;
    chk("t3_e0", {30'd0, u_dut.u_pht.mem_q[0]}, 2);
    chk("t3_st", {nbr[15:0], nmis[15:0]}, 32'h0003_0002);
    branchD = 1;
    #1 chk("t3_pred2", {31'd0, pred}, 1);
    cyc; branchD = 0; tk = 1;
    #1 chk("t3_nomis", {31'd0, mis}, 0);
    cyc;
    chk("t3_e0b", {30'd0, u_dut.u_pht.mem_q[0]}, 3);

    // Test 4: mispredict in E squashes a new D branch
    branchD = 1;
    #1 chk("t4_pred", {31'd0, pred}, 1);
    cyc; tk = 0; pcD = 32'h80; branchD = 1;
    #1;
    chk("t4_mis", {31'd0, mis}, 1);
    chk("t4_squash", {31'd0, pred}, 0);
    cyc; branchD = 0;
    #1;
    chk("t4_validE", {31'd0, u_dut.validE_q}, 0);
    chk("t4_nomis", {31'd0, mis}, 0);
    cyc;
    chk("t4_st", {nbr[15:0], nmis[15:0]}, 32'h0005_0003);

    // Test 5: flushE blocks the E record
    pcD = 32'h40; flushE = 1; branchD = 1;
    #1 chk("t5_pred", {31'd0, pred}, 1);
    cyc; flushE = 0; branchD = 0; tk = 0;
    #1;
    chk("t5_validE", {31'd0, u_dut.validE_q}, 0);
    chk("t5_nomis", {31'd0, mis}, 0);
    cyc;
    chk("t5_st", {nbr[15:0], nmis[15:0]}, 32'h0005_0003);
    chk("t5_e0", {30'd0, u_dut.u_pht.mem_q[0]}, 2);

    // Test 6: gshare, T,N,T,N,T,N at pc 0x80
    chk("t6_ready", {31'd0, g_rdy}, 1);
    for (int i = 0; i < 6; i++) begin
      g_pc = 32'h80; g_br = 1;
      #1 chk($sformatf("t6_pred%0d", i), {31'd0, g_pred}, {31'd0, exp_p[i]});
      cyc; g_br = 0; g_tk = pat[i];
      #1 chk($sformatf("t6_mis%0d", i), {31'd0, g_mis}, {31'd0, exp_m[i]});
      cyc;
      chk($sformatf("t6_ghr%0d", i), {30'd0, u_g.ghr_q}, {30'd0, exp_g[i]});
    end
    chk("t6_st", {g_nbr[15:0], g_nmis[15:0]}, 32'h0006_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
